banco_reg_multi: RTL and testbench

BANCO_REG_MULTI -- requirements
Module: banco_reg_multi

---
 rtl/banco_reg_pkg.sv | 14 +
 rtl/banco_reg_leitura.sv | 34 +++
 rtl/banco_reg_multi.sv | 107 ++++++++++
 tb/tb_banco_reg_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/banco_reg_pkg.sv
// Shared FSM encoding and default parameter values for the banco_reg register file.
package banco_reg_pkg;

  typedef enum logic {
    LIMPA  = 1'b0,
    PRONTO = 1'b1
  } estado_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_TAP_IDX  = 27;

endpackage

// File: rtl/banco_reg_leitura.sv
// One combinational read port: address decode, zero/out-of-range masking and,
// when BANCO_REG_BYPASS_EN is defined, a same-cycle write-bypass mux.
module banco_reg_leitura
  import banco_reg_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              pronto,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
`ifdef BANCO_REG_BYPASS_EN
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] reg_esc,
  input  logic [DATA_W-1:0] dado_esc,
`endif
  output logic [DATA_W-1:0] dado
);

  logic legivel;

  // Register 0 and any address past the last register always read as zero.
  assign legivel = pronto && (addr != '0) && (32'(addr) < NUM_REGS);

  always_comb begin
    dado = '0;
    if (legivel) dado = regs[addr];
`ifdef BANCO_REG_BYPASS_EN
    if (legivel && wr_ok && (reg_esc == addr)) dado = dado_esc;
`endif
  end

endmodule

// File: rtl/banco_reg_multi.sv
// Multi-port register file that clears itself one entry per cycle after reset.
// Optional same-cycle write bypass on reads: define BANCO_REG_BYPASS_EN.
module banco_reg_multi
  import banco_reg_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int TAP_IDX  = DEF_TAP_IDX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     EscreveReg,
  input  logic [ADDR_W-1:0]        reg_esc,
  input  logic [DATA_W-1:0]        dado_esc,
  input  logic [NUM_RD*ADDR_W-1:0] reg_leit,
  output logic [NUM_RD*DATA_W-1:0] dado_leit,
  output logic                     pronto,
  output logic [DATA_W-1:0]        rv
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] TAP_ADDR = ADDR_W'(TAP_IDX);

  estado_t           estado;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  // Handshake-free write: a write lands when EscreveReg is high at a rising
  // edge while pronto is high and reg_esc names a writable register.
  assign wr_ok = pronto && EscreveReg && (reg_esc != '0) && (32'(reg_esc) < NUM_REGS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado <= LIMPA;
      cnt    <= '0;
      pronto <= 1'b0;
    end else begin
      case (estado)
        LIMPA: begin
          if (cnt == CNT_LAST) begin
            estado <= PRONTO;
            pronto <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        PRONTO: begin
          estado <= PRONTO;
          pronto <= 1'b1;
        end
        default: begin
          estado <= LIMPA;
          pronto <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the LIMPA sweep zeroes it entry by entry.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (estado == LIMPA) regs[cnt] <= '0;
      else if (wr_ok) regs[reg_esc] <= dado_esc;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    banco_reg_leitura #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ADDR_W  (ADDR_W)
    ) u_rd (
      .pronto  (pronto),
      .addr    (reg_leit[k*ADDR_W +: ADDR_W]),
      .regs    (regs),
`ifdef BANCO_REG_BYPASS_EN
      .wr_ok   (wr_ok),
      .reg_esc (reg_esc),
      .dado_esc(dado_esc),
`endif
      .dado    (dado_leit[k*DATA_W +: DATA_W])
    );
  end

  // rv is simply another read port hard-wired to TAP_IDX.
  banco_reg_leitura #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_tap (
    .pronto  (pronto),
    .addr    (TAP_ADDR),
    .regs    (regs),
`ifdef BANCO_REG_BYPASS_EN
    .wr_ok   (wr_ok),
    .reg_esc (reg_esc),
    .dado_esc(dado_esc),
`endif
    .dado    (rv)
  );

endmodule

// File: tb/tb_banco_reg_multi.sv
// Self-checking bench for banco_reg_multi: default 32-register instance plus a
// 24-register single-port instance for the out-of-range address rules.
module tb_banco_reg_multi;

`ifdef BANCO_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      = 1'b0;
  logic        EscreveReg = 1'b0;
  logic [4:0]  reg_esc    = '0;
  logic [31:0] dado_esc   = '0;
  logic [9:0]  reg_leit   = '0;
  logic [63:0] dado_leit;
  logic        pronto;
  logic [31:0] rv;

  logic        b_rst_n = 1'b0;
  logic        b_we    = 1'b0;
  logic [4:0]  b_esc   = '0;
  logic [31:0] b_dado  = '0;
  logic [4:0]  b_leit  = '0;
  logic [31:0] b_out;
  logic        b_pronto;
  logic [31:0] b_rv;

  banco_reg_multi dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EscreveReg(EscreveReg),
    .reg_esc   (reg_esc),
    .dado_esc  (dado_esc),
    .reg_leit  (reg_leit),
    .dado_leit (dado_leit),
    .pronto    (pronto),
    .rv        (rv)
  );

  banco_reg_multi #(.NUM_REGS(24), .NUM_RD(1)) dut_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .EscreveReg(b_we),
    .reg_esc   (b_esc),
    .dado_esc  (b_dado),
    .reg_leit  (b_leit),
    .dado_leit (b_out),
    .pronto    (b_pronto),
    .rv        (b_rv)
  );

  // ---------------- reference model ----------------
  logic [31:0] mem [32];
  bit          m_valid = 1'b0;
  int          m_left  = 0;

  function automatic logic m_ready();
    return m_valid && (m_left == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (!m_ready() || a == 5'd0) return 32'h0;
    if (BYP && we && wa != 5'd0 && wa == a) return wd;
    return mem[a];
  endfunction

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [31:0] act_rd0, act_rd1, act_rv, exp_rd0, exp_rd1, exp_rv;
  logic        act_p, exp_p;

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    rst_n = rst; EscreveReg = we; reg_esc = wa; dado_esc = wd; reg_leit = {ra1, ra0};
    #1;
    act_rd0 = dado_leit[31:0];
    act_rd1 = dado_leit[63:32];
    act_rv  = rv;
    act_p   = pronto;
    exp_p   = m_ready();
    exp_rd0 = m_read(ra0, we, wa, wd);
    exp_rd1 = m_read(ra1, we, wa, wd);
    exp_rv  = m_read(5'd27, we, wa, wd);
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b1;
      m_left  = 32;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (we && wa != 5'd0) begin
      mem[wa] = wd;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pronto"}, {31'b0, act_p}, {31'b0, exp_p});
    chk({tag, "_rd0"}, act_rd0, exp_rd0);
    chk({tag, "_rd1"}, act_rd1, exp_rd1);
    chk({tag, "_rv"}, act_rv, exp_rv);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] erv;
  } vec_t;

  vec_t tab [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic we_r;
    logic [4:0] wa_r, ra0_r, ra1_r;
    logic [31:0] wd_r;

    tab[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'h0};
    tab[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tab[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0};
    tab[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0, 32'hDEADBEEF, 32'h0};
    tab[4] = '{1'b1, 5'd27, 32'hA5A5A5A5, 5'd27, 5'd27, BYP ? 32'hA5A5A5A5 : 32'h0,
               BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0};
    tab[5] = '{1'b0, 5'd0,  32'h0,        5'd27, 5'd27, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tab[6] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd27, BYP ? 32'h1 : 32'hDEADBEEF,
               32'hA5A5A5A5, 32'hA5A5A5A5};
    tab[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h1, 32'h0, 32'hA5A5A5A5};

    // Power-up clear: pronto low for exactly 32 cycles, reads zero, writes ignored.
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b1, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd27);
      chk("clear_pronto", {31'b0, act_p}, 32'h0);
      chk("clear_rd0", act_rd0, 32'h0);
      chk("clear_rv", act_rv, 32'h0);
    end
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
    chk("ready_pronto", {31'b0, act_p}, 32'h1);
    chk("limpa_write_ignored", act_rd0, 32'h0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tab[i].we, tab[i].wa, tab[i].wd, tab[i].ra0, tab[i].ra1);
      chk($sformatf("tab%0d_rd0", i), act_rd0, tab[i].e0);
      chk($sformatf("tab%0d_rd1", i), act_rd1, tab[i].e1);
      chk($sformatf("tab%0d_rv", i), act_rv, tab[i].erv);
    end

    // Randomized traffic against the model, with occasional resets
    for (int i = 0; i < 600; i++) begin
      we_r  = 1'($urandom_range(0, 1));
      wa_r  = 5'($urandom_range(0, 31));
      wd_r  = $urandom;
      ra0_r = ($urandom_range(0, 3) == 0) ? wa_r : 5'($urandom_range(0, 31));
      ra1_r = ($urandom_range(0, 5) == 0) ? 5'd27 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) wa_r = 5'd27;
      cycle(($urandom_range(0, 249) != 0), we_r, wa_r, wd_r, ra0_r, ra1_r);
      chk_model("rand");
    end

    // Make sure the file is ready and reg 5 holds data before the mid-clear test
    n = 0;
    while (!m_ready() && n < 64) begin
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      n++;
    end
    cycle(1'b1, 1'b1, 5'd5, 32'h5555AAAA, 5'd0, 5'd0);

    // Reset asserted at clear cycle 10: clearing restarts from index 0
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 5'd9, 32'h11111111, 5'd9, 5'd5);
      chk("midclr_rd0", act_rd0, 32'h0);
    end
    cycle(1'b0, 1'b1, 5'd9, 32'h11111111, 5'd9, 5'd5);
    n = 0;
    while (n < 64) begin
      cycle(1'b1, 1'b1, 5'd9, 32'h22222222, 5'd9, 5'd5);
      if (act_p) break;
      n++;
    end
    chk("restart_len", n, 32);
    chk("restart_reg9", act_rd0, BYP ? 32'h22222222 : 32'h0);
    chk("restart_reg5", act_rd1, 32'h0);

    // 24-register instance: address 30 is neither writable nor readable
    @(negedge clk);
    b_rst_n = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b1; b_we = 1'b1; b_esc = 5'd30; b_dado = 32'h77777777; b_leit = 5'd30;
    n = 0;
    while (n < 64) begin
      #1;
      if (b_pronto) break;
      n++;
      @(negedge clk);
    end
    chk("b_clear_len", n, 24);
    chk("b_read30_wcycle", b_out, 32'h0);
    @(negedge clk);
    #1;
    chk("b_read30_after", b_out, 32'h0);
    b_esc = 5'd23; b_dado = 32'hCAFEF00D; b_leit = 5'd23;
    #1;
    chk("b_read23_wcycle", b_out, BYP ? 32'hCAFEF00D : 32'h0);
    @(negedge clk);
    b_we = 1'b0;
    #1;
    chk("b_read23_after", b_out, 32'hCAFEF00D);
    chk("b_rv_out_of_range", b_rv, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
